// File: rtl/cache_bus_pkg.sv
// Shared types and helpers for the data-cache line bus responder.
// Holds bus geometry, engine state encodings and line-offset extraction.
package cache_bus_pkg;

  localparam int BEAT_W = 64;
  localparam int LINE_W = 128;
  localparam int OFF_W  = 4;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_WAIT  = 3'd1,
    R_BEAT0 = 3'd2,
    R_BEAT1 = 3'd3,
    R_GAP   = 3'd4
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE  = 3'd0,
    W_DATA  = 3'd1,
    W_BWAIT = 3'd2,
    W_RESP  = 3'd3,
    W_GAP   = 3'd4
  } wr_state_e;

  // Line number relative to the served window; callers slice the index and
  // use the upper bits for the range check.
  function automatic logic [63:0] line_offset(input logic [63:0] addr,
                                              input logic [63:0] base);
    return (addr - base) >> OFF_W;
  endfunction

endpackage

// File: rtl/cache_bus_responder_line_mem.sv
// Line-organised storage: one 64-bit word-select read port (asynchronous)
// and one 64-bit word-select write port; contents survive reset.
module line_mem
  import cache_bus_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic              clock,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_word,
  output logic [BEAT_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_word,
  input  logic [BEAT_W-1:0] wr_data
);

  logic [LINE_W-1:0] mem_r [2**IDX_W];

  // Word-select read; a same-cycle write is not yet visible here.
  always_comb begin
    rd_data = {BEAT_W{1'b0}};
    if (rd_word) begin
      rd_data = mem_r[rd_idx][LINE_W-1:BEAT_W];
    end else begin
      rd_data = mem_r[rd_idx][BEAT_W-1:0];
    end
  end

  // Word-select write.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (wr_word) begin
        mem_r[wr_idx][LINE_W-1:BEAT_W] <= wr_data;
      end else begin
        mem_r[wr_idx][BEAT_W-1:0] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/cache_bus_responder.sv
// Memory-side responder for the data-cache line bus: independent 2-beat
// read and write-back engines sharing one line memory.
module cache_bus_responder
  import cache_bus_pkg::*;
#(
  parameter int          IDX_W     = 10,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_valid,
  input  logic [63:0]       r_raddr,
  output logic              r_ready,
  output logic [BEAT_W-1:0] r_rdata,
  output logic              r_rlast,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [63:0]       w_waddr,
  input  logic [BEAT_W-1:0] w_wdata,
  input  logic              w_wlast,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [31:0]       stat_rd_lines,
  output logic [31:0]       stat_wr_lines
);

  localparam logic       RD_HAS_WAIT = (RD_LAT != 0);
  localparam logic       WR_HAS_WAIT = (WR_LAT != 0);
  localparam logic [3:0] RD_LAT_M1   = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_LAT_M1   = 4'(WR_LAT - 1);

  rd_state_e         rd_state_r, rd_next_s;
  logic [3:0]        rd_cnt_r, rd_cnt_next_s;
  logic [IDX_W-1:0]  rd_idx_r;
  logic              rd_in_range_r, rd_line_done_s, rd_beat_s;
  logic [31:0]       stat_rd_r;
  logic [63:0]       r_off_s;
  logic              r_in_range_s;
  logic [BEAT_W-1:0] mem_rd_data_s;

  wr_state_e         wr_state_r, wr_next_s;
  logic [3:0]        wr_cnt_r, wr_cnt_next_s;
  logic [IDX_W-1:0]  wr_idx_r;
  logic              wr_in_range_r, wr_beat_r, wr_line_done_s, wr_fire_s;
  logic [31:0]       stat_wr_r;
  logic [63:0]       w_off_s;
  logic              w_in_range_s;

  assign r_off_s      = line_offset(r_raddr, BASE_ADDR);
  assign r_in_range_s = (r_raddr >= BASE_ADDR) && ((r_off_s >> IDX_W) == 64'd0);
  assign w_off_s      = line_offset(w_waddr, BASE_ADDR);
  assign w_in_range_s = (w_waddr >= BASE_ADDR) && ((w_off_s >> IDX_W) == 64'd0);

  // Read engine next-state and wait-counter logic.
  always_comb begin
    rd_next_s      = rd_state_r;
    rd_cnt_next_s  = rd_cnt_r;
    rd_line_done_s = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        rd_cnt_next_s = 4'd0;
        if (r_valid) begin
          rd_next_s = RD_HAS_WAIT ? R_WAIT : R_BEAT0;
        end else begin
          rd_next_s = R_IDLE;
        end
      end
      R_WAIT: begin
        if (rd_cnt_r == RD_LAT_M1) begin
          rd_next_s = R_BEAT0;
        end else begin
          rd_cnt_next_s = rd_cnt_r + 4'd1;
        end
      end
      R_BEAT0: begin
        if (r_valid) begin
          rd_next_s = R_BEAT1;
        end else begin
          rd_next_s = R_BEAT0;
        end
      end
      R_BEAT1: begin
        if (r_valid) begin
          rd_next_s      = R_GAP;
          rd_line_done_s = 1'b1;
        end else begin
          rd_next_s = R_BEAT1;
        end
      end
      R_GAP:   rd_next_s = R_IDLE;
      default: rd_next_s = R_IDLE;
    endcase
  end

  // Read engine state, counter and line statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state_r <= R_IDLE;
      rd_cnt_r   <= 4'd0;
      stat_rd_r  <= 32'd0;
    end else begin
      rd_state_r <= rd_next_s;
      rd_cnt_r   <= rd_cnt_next_s;
      if (rd_line_done_s) begin
        stat_rd_r <= stat_rd_r + 32'd1;
      end
    end
  end

  // Capture the requested line when a read is accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_idx_r      <= {IDX_W{1'b0}};
      rd_in_range_r <= 1'b0;
    end else if ((rd_state_r == R_IDLE) && r_valid) begin
      rd_idx_r      <= r_off_s[IDX_W-1:0];
      rd_in_range_r <= r_in_range_s;
    end
  end

  assign rd_beat_s     = (rd_state_r == R_BEAT0) || (rd_state_r == R_BEAT1);
  assign r_ready       = rd_beat_s;
  assign r_rlast       = (rd_state_r == R_BEAT1);
  assign r_rdata       = (rd_beat_s && rd_in_range_r) ? mem_rd_data_s : {BEAT_W{1'b0}};
  assign stat_rd_lines = stat_rd_r;

  // Write engine next-state and response-delay logic.
  always_comb begin
    wr_next_s      = wr_state_r;
    wr_cnt_next_s  = wr_cnt_r;
    wr_line_done_s = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        wr_cnt_next_s = 4'd0;
        if (w_valid) begin
          wr_next_s = W_DATA;
        end else begin
          wr_next_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_valid && w_wlast) begin
          wr_next_s = WR_HAS_WAIT ? W_BWAIT : W_RESP;
        end else begin
          wr_next_s = W_DATA;
        end
      end
      W_BWAIT: begin
        if (wr_cnt_r == WR_LAT_M1) begin
          wr_next_s = W_RESP;
        end else begin
          wr_cnt_next_s = wr_cnt_r + 4'd1;
        end
      end
      W_RESP: begin
        if (b_ready) begin
          wr_next_s      = W_GAP;
          wr_line_done_s = 1'b1;
        end else begin
          wr_next_s = W_RESP;
        end
      end
      W_GAP:   wr_next_s = W_IDLE;
      default: wr_next_s = W_IDLE;
    endcase
  end

  // Write engine state, counter and line statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_r <= W_IDLE;
      wr_cnt_r   <= 4'd0;
      stat_wr_r  <= 32'd0;
    end else begin
      wr_state_r <= wr_next_s;
      wr_cnt_r   <= wr_cnt_next_s;
      if (wr_line_done_s) begin
        stat_wr_r <= stat_wr_r + 32'd1;
      end
    end
  end

  assign wr_fire_s = (wr_state_r == W_DATA) && w_valid;

  // Capture the target line on accept; beat pointer saturates at word 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_idx_r      <= {IDX_W{1'b0}};
      wr_in_range_r <= 1'b0;
      wr_beat_r     <= 1'b0;
    end else if ((wr_state_r == W_IDLE) && w_valid) begin
      wr_idx_r      <= w_off_s[IDX_W-1:0];
      wr_in_range_r <= w_in_range_s;
      wr_beat_r     <= 1'b0;
    end else if (wr_fire_s) begin
      wr_beat_r <= 1'b1;
    end
  end

  assign w_ready       = (wr_state_r == W_DATA);
  assign b_valid       = (wr_state_r == W_RESP);
  assign stat_wr_lines = stat_wr_r;

  line_mem #(
    .IDX_W (IDX_W)
  ) u_mem (
    .clock   (clock),
    .rd_idx  (rd_idx_r),
    .rd_word (rd_state_r == R_BEAT1),
    .rd_data (mem_rd_data_s),
    .wr_en   (wr_fire_s && wr_in_range_r && !reset),
    .wr_idx  (wr_idx_r),
    .wr_word (wr_beat_r),
    .wr_data (w_wdata)
  );

endmodule

// File: tb/tb_cache_bus_responder.sv
// Self-checking bench for cache_bus_responder: directed table, multi-cycle
// corner sequences and randomized traffic against a line-array model.
module tb_cache_bus_responder;

  localparam int          IDX_W  = 4;
  localparam int          NLINES = 16;
  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic        clock;
  logic        reset;
  logic        r_valid, r_ready, r_rlast;
  logic [63:0] r_raddr, r_rdata;
  logic        w_valid, w_ready, w_wlast;
  logic [63:0] w_waddr, w_wdata;
  logic        b_valid, b_ready;
  logic [31:0] stat_rd_lines, stat_wr_lines;

  cache_bus_responder #(
    .IDX_W(IDX_W), .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clock(clock), .reset(reset),
    .r_valid(r_valid), .r_raddr(r_raddr), .r_ready(r_ready),
    .r_rdata(r_rdata), .r_rlast(r_rlast),
    .w_valid(w_valid), .w_ready(w_ready), .w_waddr(w_waddr),
    .w_wdata(w_wdata), .w_wlast(w_wlast),
    .b_valid(b_valid), .b_ready(b_ready),
    .stat_rd_lines(stat_rd_lines), .stat_wr_lines(stat_wr_lines)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;
  logic [127:0] mdl [NLINES];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(NLINES * 16));
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'((a - BASE) / 64'd16);
  endfunction

  function automatic logic [127:0] model_read(input logic [63:0] a);
    if (in_rng(a)) return mdl[idx_of(a)];
    return 128'd0;
  endfunction

  // Beat 0 lands in the low word; every later beat overwrites the high word.
  task automatic model_write(input logic [63:0] a, input logic [63:0] d0, d1, d2, input int n);
    if (in_rng(a)) begin
      mdl[idx_of(a)][63:0] = d0;
      if (n == 2) mdl[idx_of(a)][127:64] = d1;
      if (n == 3) mdl[idx_of(a)][127:64] = d2;
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_stat_rd"}, 64'(stat_rd_lines), 64'(exp_rd));
    chk({tag, "_stat_wr"}, 64'(stat_wr_lines), 64'(exp_wr));
  endtask

  task automatic do_read(input logic [63:0] addr, input int drop_beat, input int drop_len,
                         output logic [63:0] q0, output logic [63:0] q1);
    int lat;
    logic [63:0] q [2];
    r_raddr = addr;
    r_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1; lat++;
    end while (!r_ready && lat < 64);
    chk("rd_latency", 64'(lat), 64'(RD_LAT + 1));
    for (int b = 0; b < 2; b++) begin
      chk("rd_ready", 64'(r_ready), 64'd1);
      chk("rd_last", 64'(r_rlast), 64'(b));
      if (b == drop_beat) begin
        r_valid = 1'b0;
        for (int k = 0; k < drop_len; k++) begin
          @(posedge clock); #1;
          chk("rd_hold_ready", 64'(r_ready), 64'd1);
          chk("rd_hold_last", 64'(r_rlast), 64'(b));
        end
        r_valid = 1'b1;
      end
      q[b] = r_rdata;
      @(posedge clock); #1;
    end
    r_valid = 1'b0;
    chk("rd_gap_ready", 64'(r_ready), 64'd0);
    @(posedge clock); #1;
    q0 = q[0];
    q1 = q[1];
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] d0, d1, d2,
                          input int n, input bit early, input bit bubbles);
    logic [63:0] d [3];
    int i, cyc, lat;
    bit fired;
    d[0] = d0; d[1] = d1; d[2] = d2;
    i = 0; cyc = 0;
    b_ready = early;
    w_waddr = addr;
    w_wdata = d[0];
    w_wlast = (n == 1);
    w_valid = 1'b1;
    while (i < n && cyc < 64) begin
      fired = w_ready && w_valid;
      @(posedge clock); #1; cyc++;
      if (fired) begin
        i++;
        if (i < n) begin
          w_wdata = d[i];
          w_wlast = (i == n - 1);
          w_valid = !(bubbles && $urandom_range(0, 2) == 0);
        end else begin
          w_valid = 1'b0;
          w_wlast = 1'b0;
        end
      end else begin
        w_valid = 1'b1;
      end
    end
    chk("wr_beats", 64'(i), 64'(n));
    lat = 1;
    while (!b_valid && lat < 64) begin
      @(posedge clock); #1; lat++;
    end
    chk("wr_b_latency", 64'(lat), 64'(WR_LAT + 1));
    chk("wr_ready_in_resp", 64'(w_ready), 64'd0);
    if (!early) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
        chk("wr_b_hold", 64'(b_valid), 64'd1);
      end
      b_ready = 1'b1;
    end
    @(posedge clock); #1;
    b_ready = 1'b0;
    chk("wr_b_pulse", 64'(b_valid), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic wr_m(input logic [63:0] addr, input logic [63:0] d0, d1, d2,
                      input int n, input bit early, input bit bubbles);
    do_write(addr, d0, d1, d2, n, early, bubbles);
    model_write(addr, d0, d1, d2, n);
    exp_wr++;
  endtask

  task automatic rd_m(input logic [63:0] addr, input int drop_beat, input int drop_len,
                      input string tag);
    logic [127:0] ex;
    logic [63:0] q0, q1;
    ex = model_read(addr);
    do_read(addr, drop_beat, drop_len, q0, q1);
    exp_rd++;
    chk({tag, "_beat0"}, q0, ex[63:0]);
    chk({tag, "_beat1"}, q1, ex[127:64]);
  endtask

  function automatic logic [63:0] rand_addr(input int idx);
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return BASE + 64'(NLINES * 16) + 64'($urandom_range(0, 255));
    if (sel == 1) return 64'($urandom_range(0, 255));
    return BASE + 64'(idx) * 64'd16 + 64'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic [63:0] addr;
    logic [63:0] d0, d1, d2;
    int          n;
    bit          early;
    logic [63:0] e0, e1;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic [63:0] q0, q1, ra, wa, w0, w1, w2;
    logic [127:0] old;
    int op, ri, wi, dbeat, dlen, nb, cyc;
    bit er;

    vecs[0] = '{BASE + 64'h30, 64'hAAAA, 64'hBBBB, 64'h0, 2, 1'b1, 64'hAAAA, 64'hBBBB};
    vecs[1] = '{BASE + 64'h50, 64'h1111, 64'h2222, 64'h0, 2, 1'b1, 64'h1111, 64'h2222};
    vecs[2] = '{BASE + 64'h6F, 64'h6060, 64'h6161, 64'h0, 2, 1'b0, 64'h6060, 64'h6161};
    vecs[3] = '{BASE + 64'h60, 64'h7777, 64'h0,    64'h0, 1, 1'b0, 64'h7777, 64'h6161};
    vecs[4] = '{BASE + 64'h68, 64'h1,    64'h2,    64'h3, 3, 1'b1, 64'h1,    64'h3};
    vecs[5] = '{BASE + 64'hF0, 64'hF0F0_0000_0000_000F, 64'h0F0F_FFFF_FFFF_FFF0, 64'h0, 2, 1'b0,
                64'hF0F0_0000_0000_000F, 64'h0F0F_FFFF_FFFF_FFF0};
    vecs[6] = '{BASE + 64'h100, 64'hDEAD, 64'hBEEF, 64'h0, 2, 1'b1, 64'h0, 64'h0};
    vecs[7] = '{64'h0, 64'hCAFE, 64'hF00D, 64'h0, 2, 1'b0, 64'h0, 64'h0};

    r_valid = 1'b0; r_raddr = 64'd0;
    w_valid = 1'b0; w_waddr = 64'd0; w_wdata = 64'd0; w_wlast = 1'b0;
    b_ready = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_r_ready", 64'(r_ready), 64'd0);
    chk("rst_r_rlast", 64'(r_rlast), 64'd0);
    chk("rst_r_rdata", r_rdata, 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk_stats("rst");
    reset = 1'b0;

    for (int i = 0; i < NLINES; i++) begin
      wr_m(BASE + 64'(i) * 64'd16, {32'hC0DE_0000, 32'(i)}, {32'hC0DE_1111, 32'(i)},
           64'd0, 2, 1'b1, 1'b0);
    end

    for (int v = 0; v < 8; v++) begin
      wr_m(vecs[v].addr, vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].n, vecs[v].early, 1'b0);
      do_read(vecs[v].addr, -1, 0, q0, q1);
      exp_rd++;
      chk("tbl_beat0", q0, vecs[v].e0);
      chk("tbl_beat1", q1, vecs[v].e1);
    end
    chk_stats("tbl");

    for (int i = 0; i < NLINES; i++) rd_m(BASE + 64'(i) * 64'd16, -1, 0, "sweep1");

    rd_m(BASE + 64'h30, 1, 3, "drop_beat1");
    chk_stats("drop");

    fork
      wr_m(BASE + 64'h50, 64'h5A5A, 64'h5B5B, 64'h0, 2, 1'b1, 1'b0);
      rd_m(BASE + 64'h70, -1, 0, "conc_rd7");
    join
    rd_m(BASE + 64'h50, -1, 0, "conc_rd5");
    chk_stats("conc");

    old = mdl[9];
    fork
      do_read(BASE + 64'h90, -1, 0, q0, q1);
      begin
        repeat (2) begin @(posedge clock); #1; end
        do_write(BASE + 64'h90, 64'h9000, 64'h9001, 64'h0, 2, 1'b1, 1'b0);
      end
    join
    model_write(BASE + 64'h90, 64'h9000, 64'h9001, 64'h0, 2);
    exp_rd++; exp_wr++;
    chk("rbw_same_cycle_beat0", q0, old[63:0]);
    chk("rbw_same_cycle_beat1", q1, old[127:64]);

    fork
      do_read(BASE + 64'h90, -1, 0, q0, q1);
      begin
        @(posedge clock); #1;
        do_write(BASE + 64'h90, 64'h9100, 64'h9101, 64'h0, 2, 1'b1, 1'b0);
      end
    join
    model_write(BASE + 64'h90, 64'h9100, 64'h9101, 64'h0, 2);
    exp_rd++; exp_wr++;
    chk("rbw_earlier_beat0", q0, 64'h9100);
    chk("rbw_earlier_beat1", q1, 64'h9101);
    chk_stats("rbw");

    w_waddr = BASE + 64'hB0; w_wdata = 64'h0B0B_0000; w_wlast = 1'b0; w_valid = 1'b1;
    cyc = 0;
    while (!w_ready && cyc < 16) begin
      @(posedge clock); #1; cyc++;
    end
    chk("rst_mid_wready_seen", 64'(w_ready), 64'd1);
    @(posedge clock); #1;
    w_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_rd = 0; exp_wr = 0;
    mdl[11][63:0] = 64'h0B0B_0000;
    chk("rst_mid_w_ready", 64'(w_ready), 64'd0);
    chk("rst_mid_b_valid", 64'(b_valid), 64'd0);
    chk_stats("rst_mid");
    rd_m(BASE + 64'hB0, -1, 0, "rst_mid_persist");
    wr_m(BASE + 64'hB0, 64'hB1B1, 64'hB2B2, 64'h0, 2, 1'b0, 1'b0);
    rd_m(BASE + 64'hB0, -1, 0, "rst_mid_fresh");
    chk_stats("rst_mid_after");

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      ri = $urandom_range(0, NLINES - 1);
      wi = (ri + $urandom_range(1, NLINES - 1)) % NLINES;
      ra = rand_addr(ri);
      wa = rand_addr(wi);
      w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom};
      nb = $urandom_range(1, 3);
      er = 1'($urandom_range(0, 1));
      dbeat = $urandom_range(0, 3);
      dlen = $urandom_range(1, 3);
      if (op == 0) begin
        rd_m(ra, dbeat, dlen, "rand_rd");
      end else if (op == 1) begin
        wr_m(wa, w0, w1, w2, nb, er, 1'b1);
      end else begin
        fork
          rd_m(ra, dbeat, dlen, "rand_conc_rd");
          wr_m(wa, w0, w1, w2, nb, er, 1'b1);
        join
      end
      chk_stats("rand");
    end

    for (int i = 0; i < NLINES; i++) rd_m(BASE + 64'(i) * 64'd16, -1, 0, "sweep2");
    chk_stats("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_bus_responder.md
Name: cache_bus_responder

Overview:
Slave/responder end of the data-cache line bus. It serves 2-beat (2x64-bit) line reads and 2-beat line write-backs with a B response from a local line-organised memory. The read and write engines are independent and may be active at the same time, because the cache issues a victim write-back and a refill read concurrently. It serves as the memory-side model/bridge under the DCache in simulation and small SoC configs.

Parameters:
IDX_W, 10, line-index bits; memory holds 2^IDX_W lines of 128 bits.
BASE_ADDR, 64'h8000_0000, first byte address served; must be 16-byte aligned.
RD_LAT, 2, extra wait cycles before the first read beat (0..15).
WR_LAT, 1, extra wait cycles between the last write beat and b_valid (0..15).

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
r_valid  in  1  read request; held high by the initiator until the rlast beat fires
r_raddr  in  64  line address; bits[3:0] are ignored
r_ready  out  1  beat strobe; a beat transfers when r_valid&r_ready
r_rdata  out  64  beat data; valid while r_ready=1
r_rlast  out  1  high on beat 1 only
w_valid  in  1  write beat valid
w_ready  out  1  write beat accept
w_waddr  in  64  line address; constant across both beats; bits[3:0] are ignored
w_wdata  in  64  beat data
w_wlast  in  1  marks the final beat
b_valid  out  1  write response
b_ready  in  1  write response accept
stat_rd_lines  out  32  count of completed line reads
stat_wr_lines  out  32  count of completed line writes

Behaviour:
- Reset: sync, active-high. Both FSMs go to IDLE, the wait counters clear, and r_ready, r_rlast, w_ready and b_valid go to 0. r_rdata resets to 0. The stat counters reset to 0. Memory contents are not reset and are preserved across a reset.
- Index = addr[IDX_W+3:4] after subtracting BASE_ADDR. An address is in range iff BASE_ADDR <= addr < BASE_ADDR + 2^(IDX_W+4).
- Read FSM states are R_IDLE, R_WAIT, R_BEAT0, R_BEAT1, R_GAP.
  - R_IDLE with r_valid=1: latch the line index and the in-range flag. Go to R_WAIT if RD_LAT>0, else to R_BEAT0.
  - R_WAIT: count RD_LAT cycles, then go to R_BEAT0. The first r_ready therefore appears RD_LAT+1 cycles after r_valid is sampled.
  - R_BEAT0: r_ready=1 and r_rdata = line[63:0]. On fire, go to R_BEAT1.
  - R_BEAT1: r_ready=1, r_rlast=1 and r_rdata = line[127:64]. On fire, increment stat_rd_lines and go to R_GAP.
  - R_GAP: one idle cycle (r_ready=0), then R_IDLE. This guarantees the initiator's registered r_valid drop is seen.
  - r_valid low during a BEAT state: hold the state, keep r_ready high and do not advance.
  - An out-of-range read returns 0 data but still completes the full 2-beat response.
  - Read data is sampled from the array in the cycle the beat is presented.
- Write FSM states are W_IDLE, W_DATA, W_BWAIT, W_RESP, W_GAP.
  - W_IDLE with w_valid=1: latch the index and the in-range flag, clear the beat counter and go to W_DATA. w_ready is 0 in W_IDLE.
  - W_DATA: w_ready=1. On each fire, write w_wdata to word[beat] (beat 0 = [63:0], beat 1 = [127:64]) if in range. The beat counter saturates at 1, so any extra beats overwrite word 1.
  - W_DATA fire with w_wlast=1: go to W_BWAIT if WR_LAT>0, else to W_RESP. A wlast on beat 0 is legal and writes word 0 only.
  - W_RESP: b_valid=1, held until b_ready. On fire, increment stat_wr_lines and go to W_GAP, then W_IDLE. b_ready may already be high when b_valid rises (the DCache raises it early); the fire then occurs in the first W_RESP cycle.
  - An out-of-range write drops its data but still returns b.
- Simultaneous read and write:
  - The engines run fully in parallel.
  - Same-cycle read beat and write beat to the same line word: the read returns the old data (read-before-write).
  - A write committed in an earlier cycle is visible to any later read beat.
- Stat counters wrap modulo 2^32.
- Both engines use one-hot or binary encoding; all outputs are registered-state decodes with no combinational path from inputs to outputs.

Decomposition:
- Shared package cache_bus_pkg holds:
  - the beat width (64) and line width (128)
  - the offset bits (4)
  - read/write state enums
  - the line index extraction function
- One natural sub-module is line_mem: a 2^IDX_W x 128 array with one 64-bit word-select read port and one 64-bit word-select write port, no reset. Both FSMs are instantiated inline in cache_bus_responder.

Test Plan:
- Preload line idx 3 = {64'hBBBB, 64'hAAAA}; RD_LAT=2; hold r_valid with r_raddr=BASE+0x30 → r_ready rises 3 cycles later; beats 64'hAAAA (rlast=0) then 64'hBBBB (rlast=1) in consecutive cycles; stat_rd_lines=1.
- Write BASE+0x50 with beats 64'h1111 then 64'h2222 (wlast on beat 2) and b_ready high early → b_valid WR_LAT+1=2 cycles after the last beat, for 1 cycle; a subsequent read of 0x50 returns 1111, 2222.
- Concurrent write-back to idx 5 and refill read of idx 7, started in the same cycle → both complete; idx 7 data unaffected; idx 5 updated; stat counters both 1.
- Out-of-range read at addr 0x0 → two beats of 0 with rlast; out-of-range write → b_valid returned, and memory checksum unchanged.
- r_valid dropped for 3 cycles in R_BEAT1 → r_ready stays high, no extra beat, and the response completes when r_valid returns.
- Assert reset during W_DATA after beat 0 → w_ready=0, b_valid=0 and counters 0 the next cycle; word 0 written before the reset persists, and a fresh write transaction afterwards succeeds.
